// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns an execute-stage memory access into one request/ack
// transaction on the data bus and returns aligned, extended load data.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_BUS     = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~a[0];
                3'b010:  ok = (a == 2'b00);
                3'b100:  ok = rd;
                3'b101:  ok = rd & ~a[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  fault_q, fault_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        access;

    assign access  = req_valid & (mem_read | mem_write);
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    rdata_d = 32'd0;
                    if (access_legal(mem_read, mem_write, funct3, addr[1:0])) begin
                        state_d     = REQ;
                        cnt_d       = 8'd0;
                        is_load_d   = mem_read;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        fault_d     = FAULT_OK;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = lane_enables(funct3, addr[1:0]);
                        bus_wdata_d = lane_replicate(funct3, wdata);
                    end else begin
                        // Illegal accesses never touch the bus.
                        state_d      = RESP;
                        fault_d      = FAULT_ILLEGAL;
                        resp_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    if (bus_err) begin
                        fault_d = FAULT_BUS;
                        rdata_d = 32'd0;
                    end else begin
                        fault_d = FAULT_OK;
                        rdata_d = is_load_q ? load_extract(funct3_q, off_q, bus_rdata) : 32'd0;
                    end
                end else if (cnt_inc >= TIMEOUT_LIM) begin
                    state_d      = RESP;
                    cnt_d        = cnt_inc[7:0];
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    fault_d      = FAULT_TIMEOUT;
                    rdata_d      = 32'd0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            fault_q      <= FAULT_OK;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_be_q     <= 4'd0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Stall must cover the accept cycle itself, so it looks at the live request.
    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q == REQ) | ((state_q == IDLE) & access);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised bench for lsu_mem_ctrl: the bench plays the memory and predicts
// every cycle of each transaction from the access rules.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, stall, resp_valid;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid), .rdata(rdata),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata)
    );

    typedef struct {
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        delay;
        bit        err;
        bit [31:0] word;
        bit        early;
        bit        pin;
        bit [31:0] pin_rdata;
        bit [1:0]  pin_fault;
    } txn_t;

    int n_vec  = 0;
    int n_miss = 0;

    bit          chk_en = 1'b0;
    bit          chk_out = 1'b0;
    bit          chk_bus = 1'b0;
    logic        e_ready, e_stall, e_rv, e_breq, e_bwe;
    logic [1:0]  e_fault;
    logic [31:0] e_rdata, e_baddr, e_bwdata;
    logic [3:0]  e_bbe;
    logic [31:0] last_rdata;
    logic [1:0]  last_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(input txn_t t);
        bit ok;
        if (t.rd && t.wr)       ok = 1'b0;
        else if (t.f3 == 3'd0)  ok = 1'b1;
        else if (t.f3 == 3'd1)  ok = (t.addr % 2 == 0);
        else if (t.f3 == 3'd2)  ok = (t.addr % 4 == 0);
        else if (t.f3 == 3'd4)  ok = t.rd;
        else if (t.f3 == 3'd5)  ok = t.rd && (t.addr % 2 == 0);
        else                    ok = 1'b0;
        return ok;
    endfunction

    function automatic int m_size(input bit [2:0] f3);
        int s;
        if (f3 % 4 == 0)      s = 1;
        else if (f3 % 4 == 1) s = 2;
        else                  s = 4;
        return s;
    endfunction

    function automatic logic [3:0] m_be(input txn_t t);
        int v;
        v = ((1 << m_size(t.f3)) - 1) << (t.addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input txn_t t);
        logic [31:0] r;
        int sz;
        sz = m_size(t.f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = t.wdata[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input txn_t t);
        longint v;
        int sz;
        int o;
        if (!t.rd) return 32'd0;
        sz = m_size(t.f3);
        o  = int'(t.addr % 4);
        v  = longint'(t.word >> (8 * o));
        if (sz == 1) begin
            v = v % 256;
            if (t.f3 < 3'd4 && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (t.f3 < 3'd4 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(t.word);
        end
        return 32'(v);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  32'(req_ready),  32'(e_ready));
            chk("stall",      32'(stall),      32'(e_stall));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("bus_req",    32'(bus_req),    32'(e_breq));
            if (chk_out) begin
                chk("rdata", rdata, e_rdata);
                chk("fault", 32'(fault), 32'(e_fault));
            end
            if (chk_bus) begin
                chk("bus_addr",  bus_addr,       e_baddr);
                chk("bus_be",    32'(bus_be),    32'(e_bbe));
                chk("bus_we",    32'(bus_we),    32'(e_bwe));
                chk("bus_wdata", bus_wdata,      e_bwdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_ready = 1'b1; e_stall = 1'b0; e_rv = 1'b0; e_breq = 1'b0;
        chk_out = 1'b1; chk_bus = 1'b0;
        e_rdata = last_rdata; e_fault = last_fault;
    endtask

    task automatic drive_req(input txn_t t);
        req_valid = 1'b1; mem_read = t.rd; mem_write = t.wr;
        funct3 = t.f3; addr = t.addr; wdata = t.wdata;
    endtask

    task automatic drive_noreq();
        logic [31:0] r;
        r = $urandom;
        req_valid = r[0];
        mem_read  = r[0] ? 1'b0 : r[1];
        mem_write = r[0] ? 1'b0 : r[2];
        funct3 = r[5:3]; addr = $urandom; wdata = $urandom;
    endtask

    task automatic rand_bus();
        bus_ack = 1'($urandom_range(0, 1)); bus_err = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
    endtask

    task automatic do_txn(input txn_t t, input txn_t nx);
        int n;
        drive_req(t);
        rand_bus();
        idle_exp();
        e_stall = 1'b1;
        cyc();
        drive_noreq();
        if (m_legal(t)) begin
            n = (t.delay <= TO) ? t.delay : TO;
            e_ready = 1'b0; e_stall = 1'b1; e_rv = 1'b0; e_breq = 1'b1;
            chk_out = 1'b0; chk_bus = 1'b1;
            e_baddr = t.addr & 32'hFFFF_FFFC; e_bwe = t.wr;
            e_bbe = m_be(t); e_bwdata = m_wdata(t);
            for (int k = 1; k <= n; k++) begin
                bus_ack   = (k == t.delay);
                bus_err   = (k == t.delay) ? t.err : 1'($urandom_range(0, 1));
                bus_rdata = (k == t.delay) ? t.word : $urandom;
                drive_noreq();
                cyc();
            end
            if (t.delay <= TO) begin
                last_fault = t.err ? 2'b10 : 2'b00;
                last_rdata = t.err ? 32'd0 : m_rdata(t);
            end else begin
                last_fault = 2'b11;
                last_rdata = 32'd0;
            end
        end else begin
            last_fault = 2'b01;
            last_rdata = 32'd0;
        end
        e_ready = 1'b0; e_stall = 1'b0; e_rv = 1'b1; e_breq = 1'b0;
        chk_out = 1'b1; chk_bus = 1'b0;
        e_rdata = last_rdata; e_fault = last_fault;
        rand_bus();
        if (nx.early) drive_req(nx);
        else drive_noreq();
        if (t.pin) begin
            chk("pin_resp_valid", 32'(resp_valid), 32'd1);
            chk("pin_rdata", rdata, t.pin_rdata);
            chk("pin_fault", 32'(fault), 32'(t.pin_fault));
        end
        cyc();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_noreq();
            rand_bus();
            idle_exp();
            cyc();
        end
    endtask

    function automatic txn_t mk(input bit rd, input bit wr, input bit [2:0] f3,
                                input bit [31:0] a, input bit [31:0] wd, input int dly,
                                input bit err, input bit [31:0] word,
                                input bit [31:0] prd, input bit [1:0] pf);
        txn_t t;
        t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = a; t.wdata = wd; t.delay = dly;
        t.err = err; t.word = word; t.early = 1'b0; t.pin = 1'b1;
        t.pin_rdata = prd; t.pin_fault = pf;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int s;
        int k;
        s = $urandom_range(0, 9);
        t.rd = (s < 5) || (s == 9);
        t.wr = (s >= 5);
        if ($urandom_range(0, 9) < 8) begin
            k = $urandom_range(0, 4);
            t.f3 = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd4 : 3'd5;
        end else begin
            t.f3 = 3'($urandom_range(0, 7));
        end
        t.addr = $urandom;
        if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
        t.wdata = $urandom; t.word = $urandom;
        t.delay = $urandom_range(1, 6);
        t.err = ($urandom_range(0, 4) == 0);
        t.early = ($urandom_range(0, 2) == 0);
        t.pin = 1'b0; t.pin_rdata = 32'd0; t.pin_fault = 2'd0;
        return t;
    endfunction

    txn_t dq[$];
    txn_t rq[$];
    txn_t blank;
    txn_t nx;
    txn_t r;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        blank = mk(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1, 1'b0, 32'd0, 32'd0, 2'd0);
        blank.pin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_stall",      32'(stall),      32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata",      rdata,           32'd0);
        chk("rst_fault",      32'(fault),      32'd0);
        chk("rst_bus_req",    32'(bus_req),    32'd0);
        chk("rst_bus_we",     32'(bus_we),     32'd0);
        chk("rst_bus_addr",   bus_addr,        32'd0);
        chk("rst_bus_be",     32'(bus_be),     32'd0);
        chk("rst_bus_wdata",  bus_wdata,       32'd0);
        rst_n = 1'b1;
        last_rdata = 32'd0; last_fault = 2'd0;
        idle_exp();
        chk_en = 1'b1;
        cyc();

        dq.push_back(mk(1, 0, 3'b010, 32'h0000_1004, 32'h0, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00));
        dq.push_back(mk(1, 0, 3'b000, 32'h0000_2003, 32'h0, 1, 0, 32'h80FF_0011, 32'hFFFF_FF80, 2'b00));
        dq.push_back(mk(1, 0, 3'b100, 32'h0000_2003, 32'h0, 2, 0, 32'h80FF_0011, 32'h0000_0080, 2'b00));
        dq[2].early = 1'b1;
        dq.push_back(mk(0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 3, 0, 32'h5555_5555, 32'h0, 2'b00));
        dq.push_back(mk(1, 0, 3'b010, 32'h0000_4006, 32'h0, 1, 0, 32'h0, 32'h0, 2'b01));
        dq.push_back(mk(1, 0, 3'b001, 32'h0000_4001, 32'h0, 1, 0, 32'h0, 32'h0, 2'b01));
        dq.push_back(mk(1, 0, 3'b011, 32'h0000_4000, 32'h0, 1, 0, 32'h0, 32'h0, 2'b01));
        dq.push_back(mk(1, 1, 3'b010, 32'h0000_4000, 32'h0, 1, 0, 32'h0, 32'h0, 2'b01));
        dq.push_back(mk(1, 0, 3'b101, 32'h0000_5002, 32'h0, 4, 0, 32'h8001_7FFF, 32'h0000_8001, 2'b00));
        dq.push_back(mk(1, 0, 3'b010, 32'h0000_6000, 32'h0, 10, 0, 32'h0, 32'h0, 2'b11));
        dq.push_back(mk(1, 0, 3'b010, 32'h0000_7000, 32'h0, 2, 1, 32'h1234_5678, 32'h0, 2'b10));

        for (int i = 0; i < dq.size(); i++) begin
            nx = (i + 1 < dq.size()) ? dq[i+1] : blank;
            do_txn(dq[i], nx);
            if (!nx.early) idle_cycles(1);
        end

        // spurious ack in IDLE after the timeout/error cases
        drive_noreq();
        bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        idle_exp();
        cyc();

        // reset while a transaction is outstanding
        r = mk(1, 0, 3'b010, 32'h0000_0200, 32'h0, 100, 0, 32'h0, 32'h0, 2'b00);
        drive_req(r); bus_ack = 1'b0; idle_exp(); e_stall = 1'b1;
        cyc();
        drive_noreq();
        e_ready = 1'b0; e_stall = 1'b1; e_rv = 1'b0; e_breq = 1'b1;
        chk_out = 1'b0; chk_bus = 1'b1;
        e_baddr = 32'h0000_0200; e_bwe = 1'b0; e_bbe = 4'hF; e_bwdata = 32'h0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        last_rdata = 32'd0; last_fault = 2'd0;
        chk("mid_rst_bus_addr", bus_addr, 32'd0);
        chk("mid_rst_bus_be",   32'(bus_be), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive_noreq();
            bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = $urandom;
            idle_exp();
            cyc();
        end

        for (int i = 0; i < 300; i++) rq.push_back(rand_txn());
        rq[0].early = 1'b0;
        for (int i = 0; i < rq.size(); i++) begin
            nx = (i + 1 < rq.size()) ? rq[i+1] : blank;
            do_txn(rq[i], nx);
            if (!nx.early) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
